// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Decodes 16-bit instruction words into the register-file /
//            operand-mux / ALU control set and holds each set for
//            STEP_CYCLES cycles so the ALU result is written back.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   instr_valid  in   instruction word present on instr
//   instr[15:0]  in   [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4
//   Overflow     in   ALU overflow, sampled on the last EXEC cycle only
//   instr_ready  out  instruction accepted this cycle when instr_valid
//   ReadRgAddr1  out  first source register
//   ReadRgAddr2  out  second source register
//   WriteRgAddr  out  destination register (0 = no write)
//   immediate    out  zero-extended imm4
//   sel          out  operand mux select (1 = immediate)
//   Control      out  ALU operation code
//   busy         out  executing an instruction
//   halted       out  HALT retired; stays set until reset
//   ovf_flag     out  sticky overflow of a retired instruction
//   illegal_flag out  sticky undefined opcode retired
//   retired      out  retired-instruction count, modulo 256
// ============================================================================
module alu_sequencer #(
    parameter int STEP_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    input  logic        Overflow,
    output logic        instr_ready,
    output logic [3:0]  ReadRgAddr1,
    output logic [3:0]  ReadRgAddr2,
    output logic [3:0]  WriteRgAddr,
    output logic [15:0] immediate,
    output logic        sel,
    output logic [3:0]  Control,
    output logic        busy,
    output logic        halted,
    output logic        ovf_flag,
    output logic        illegal_flag,
    output logic [7:0]  retired
);

    localparam int            CW     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] c_LOAD = CW'(STEP_CYCLES - 1);

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_ADDI = 4'h2;
    localparam logic [3:0] c_OP_SUB  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_SLT  = 4'h6;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_rs, r_rt, r_rd, r_ctrl;
    logic [15:0]   r_imm;
    logic          r_sel, r_ovf_en, r_illegal;
    logic          r_ovf_flag, r_illegal_flag;
    logic [7:0]    r_retired;

    logic          w_accept, w_busy, w_last;
    logic [3:0]    w_op;
    logic [3:0]    w_dec_rs, w_dec_rt, w_dec_rd, w_dec_ctrl;
    logic [15:0]   w_dec_imm;
    logic          w_dec_sel, w_dec_ovf_en, w_dec_illegal;

    // Ready is masked while reset is asserted so nothing is accepted then.
    assign instr_ready = (r_state == S_IDLE) && rst;
    assign w_accept    = instr_ready && instr_valid;
    assign w_busy      = (r_state == S_EXEC);
    assign w_last      = w_busy && (r_cnt == '0);
    assign w_op        = instr[15:12];

    // Instruction decode; NOP, HALT and illegal opcodes leave everything 0.
    always_comb begin
        w_dec_rs      = 4'h0;
        w_dec_rt      = 4'h0;
        w_dec_rd      = 4'h0;
        w_dec_ctrl    = 4'b0000;
        w_dec_imm     = 16'h0000;
        w_dec_sel     = 1'b0;
        w_dec_ovf_en  = 1'b0;
        w_dec_illegal = 1'b0;
        case (w_op)
            c_OP_NOP, c_OP_HALT: ;
            c_OP_ADD, c_OP_ADDI, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SLT: begin
                w_dec_rs     = instr[7:4];
                w_dec_rt     = instr[3:0];
                w_dec_rd     = instr[11:8];
                w_dec_ovf_en = 1'b1;
                case (w_op)
                    c_OP_ADD:  w_dec_ctrl = 4'b0010;
                    c_OP_ADDI: begin
                        w_dec_ctrl = 4'b0010;
                        w_dec_sel  = 1'b1;
                        w_dec_imm  = {12'h000, instr[3:0]};
                    end
                    c_OP_SUB:  w_dec_ctrl = 4'b0110;
                    c_OP_AND:  w_dec_ctrl = 4'b0000;
                    c_OP_OR:   w_dec_ctrl = 4'b0001;
                    default:   w_dec_ctrl = 4'b0111;
                endcase
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    // FSM next state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_op == c_OP_HALT) ? S_HALTED : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            S_HALTED: w_next_state = S_HALTED;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched control set, step counter and retirement bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_rs           <= 4'h0;
            r_rt           <= 4'h0;
            r_rd           <= 4'h0;
            r_ctrl         <= 4'h0;
            r_imm          <= 16'h0000;
            r_sel          <= 1'b0;
            r_ovf_en       <= 1'b0;
            r_illegal      <= 1'b0;
            r_ovf_flag     <= 1'b0;
            r_illegal_flag <= 1'b0;
            r_retired      <= 8'h00;
        end else if (w_accept) begin
            r_cnt     <= c_LOAD;
            r_rs      <= w_dec_rs;
            r_rt      <= w_dec_rt;
            r_rd      <= w_dec_rd;
            r_ctrl    <= w_dec_ctrl;
            r_imm     <= w_dec_imm;
            r_sel     <= w_dec_sel;
            r_ovf_en  <= w_dec_ovf_en;
            r_illegal <= w_dec_illegal;
            // HALT never enters EXEC, so it retires on acceptance.
            if (w_op == c_OP_HALT) begin
                r_retired <= r_retired + 8'd1;
            end
        end else if (w_busy) begin
            if (w_last) begin
                r_retired      <= r_retired + 8'd1;
                r_ovf_flag     <= r_ovf_flag | (r_ovf_en & Overflow);
                r_illegal_flag <= r_illegal_flag | r_illegal;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Control set is only driven while executing; idle/halted outputs are 0.
    assign ReadRgAddr1  = w_busy ? r_rs   : 4'h0;
    assign ReadRgAddr2  = w_busy ? r_rt   : 4'h0;
    assign WriteRgAddr  = w_busy ? r_rd   : 4'h0;
    assign immediate    = w_busy ? r_imm  : 16'h0000;
    assign sel          = w_busy ? r_sel  : 1'b0;
    assign Control      = w_busy ? r_ctrl : 4'b0000;
    assign busy         = w_busy;
    assign halted       = (r_state == S_HALTED);
    assign ovf_flag     = r_ovf_flag;
    assign illegal_flag = r_illegal_flag;
    assign retired      = r_retired;

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction sequencer that drives the register-file / operand-mux / ALU datapath from 16-bit instruction words. Each accepted instruction is decoded into the datapath control set: read addresses, write address, immediate, mux select and ALU control. The set is held for a fixed number of cycles so the ALU result is written back, replacing hand-timed control sequences. It sits between an instruction source (bench or program ROM) and the existing memory/mux/alu instances.

## Interface
Parameters:
- STEP_CYCLES, 3, cycles each instruction's control set is held in EXEC (≥1; 3 = 30 time units at a 10-unit clock)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising edge of clk)
- instr_valid  in  1  instruction word present on instr
- instr  in  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt or imm4
- Overflow  in  1  ALU overflow, sampled on the last EXEC cycle
- instr_ready  out  1  sequencer accepts instr this cycle
- ReadRgAddr1  out  4  first source register (rs)
- ReadRgAddr2  out  4  second source register (rt)
- WriteRgAddr  out  4  destination register; 0 = no architectural write ($zero)
- immediate  out  16  zero-extended imm4
- sel  out  1  operand mux select: 1 = immediate, 0 = ReadData2
- Control  out  4  ALU operation code
- busy  out  1  in EXEC
- halted  out  1  HALT retired
- ovf_flag  out  1  sticky: some retired instruction overflowed
- illegal_flag  out  1  sticky: undefined opcode received
- retired  out  8  retired-instruction count, wraps 255→0

## Operation
- Opcodes and their Control/sel values:
  - 0x0 NOP: Control 0000, WriteRgAddr 0
  - 0x1 ADD: Control 0010, sel 0
  - 0x2 ADDI: Control 0010, sel 1
  - 0x3 SUB: Control 0110, sel 0
  - 0x4 AND: Control 0000, sel 0
  - 0x5 OR: Control 0001, sel 0
  - 0x6 SLT: Control 0111, sel 0
  - 0xF HALT
  - all others illegal
- ADDI: ReadRgAddr2 = instr[3:0]; immediate = {12'b0, instr[3:0]}. Other ops: immediate = 0.
- Illegal opcode: executes as NOP (full STEP_CYCLES, counts as retired) and sets illegal_flag.
- States:
  - IDLE: instr_ready=1; WriteRgAddr=0, sel=0, Control=0000. On instr_valid, latch the decoded fields; go to EXEC, or HALTED if opcode=0xF.
  - EXEC: decoded outputs held constant; down-counter loads STEP_CYCLES-1. On count 0: retired+1, ovf_flag |= Overflow (not for NOP/illegal), go to IDLE.
  - HALTED: instr_ready=0; halted=1; idle outputs; HALT counts as retired. The block stays in HALTED until rst.
- Only one instruction is in flight at a time; instr_ready is never high in EXEC or HALTED.

## Timing
- Reset (rst=0 at edge): state IDLE on the next cycle.
  - All address outputs, immediate, Control, sel, busy, halted, ovf_flag, illegal_flag and retired = 0.
  - instr_ready = 1 once rst=1.
- rst=0 in EXEC aborts the instruction: it is not retired and no flags are updated.
- Handshake: transfer when instr_valid && instr_ready at a rising edge. instr is ignored otherwise and need not be held after the transfer.
- Latency: the decoded outputs are registered and appear in the cycle after acceptance. They stay valid for exactly STEP_CYCLES cycles.
- WriteRgAddr returns to 0 on the cycle after the last EXEC cycle, which guarantees no stray write.
- Throughput: one instruction per STEP_CYCLES+1 cycles.
- retired and the sticky flags update on the same edge that leaves EXEC. retired wraps modulo 256 without saturation.
- Overflow is ignored in every cycle except the last EXEC cycle.

## Test plan
- Reset: hold rst=0 for 2 cycles with instr_valid=1 → all outputs 0 and instr_ready=0 during reset; nothing is accepted; after release, instr_ready=1.
- ADDI: instr=16'h2205 → next cycle ReadRgAddr1=0, ReadRgAddr2=5, WriteRgAddr=2, sel=1, immediate=16'h0005, Control=0010 for 3 cycles; then WriteRgAddr=0 and retired=1.
- Sum loop: on the full datapath, issue 16'h2200, then 10× {ADD 16'h1112, ADDI 16'h2221} → reg1=45, reg2=10, retired=21.
- Overflow/illegal: SUB with Overflow=1 only on the last EXEC cycle → ovf_flag=1. Opcode 0x8 → illegal_flag=1, WriteRgAddr stays 0, retired increments.
- HALT: 16'hF000 → halted=1, instr_ready=0; a following ADD is never accepted; rst clears halted.
- Abort: rst=0 on the 2nd EXEC cycle of ADD → retired unchanged, WriteRgAddr=0 on the next cycle.
